// File: rtl/npc_ctrl_pkg.sv
// Shared definitions for the core_seq instruction sequencer: FSM states,
// RV32 major opcodes, trap cause codes and the EBREAK encoding.
package npc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT,
        ST_TRAP
    } state_e;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL   = 2'b01;
    localparam logic [1:0] CAUSE_FETCH_TMO = 2'b10;

    localparam logic [31:0] EBREAK_INST = 32'h00100073;

    function automatic logic opcode_legal(input logic [6:0] op);
        case (op)
            OP_OP, OP_IMM, OP_LOAD, OP_JALR, OP_STORE,
            OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_SYSTEM: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Stores, branches and SYSTEM never write back; x0 writes are dropped.
    function automatic logic writes_rd(input logic [6:0] op, input logic [4:0] rd);
        logic wr;
        case (op)
            OP_OP, OP_IMM, OP_LOAD, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL: wr = 1'b1;
            default: wr = 1'b0;
        endcase
        return wr && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/core_seq_timer.sv
// Fetch watchdog: counts enabled cycles from zero and flags the last
// permitted cycle; clear has priority and also serves as reset.
module core_seq_timer #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/core_seq.sv
// Multi-cycle instruction sequencer: IDLE, FETCH, DECODE, EXEC, WB, HALT, TRAP.
// Optional retire counter port enabled by defining CORE_SEQ_RETIRE_CNT_EN.
module core_seq
    import npc_ctrl_pkg::*;
#(
    parameter int          FETCH_TIMEOUT = 256,
    parameter logic [31:0] RESET_INST    = 32'h00000013
) (
    input  logic        clk,
    input  logic        global_rst,
    input  logic [31:0] pc_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        ex_start,
    input  logic        ex_busy,
    output logic        reg_we,
    output logic        pc_we,
    output logic        halt,
    output logic        trap,
    output logic [1:0]  trap_cause
`ifdef CORE_SEQ_RETIRE_CNT_EN
    ,
    output logic [63:0] retire_cnt
`endif
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic [1:0]  cause_q, cause_d;
    logic        ex_start_q, ex_start_d;
    logic        tmr_clear, tmr_enable, tmr_expired;

    assign tmr_enable = (state_q == ST_FETCH);
    assign tmr_clear  = global_rst || (state_q != ST_FETCH);

    core_seq_timer #(.LIMIT(FETCH_TIMEOUT)) u_timer (
        .clk     (clk),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        cause_d = cause_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH: begin
                // A late ack beats the timeout in the same cycle.
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    state_d = ST_DECODE;
                end else if (tmr_expired) begin
                    cause_d = CAUSE_FETCH_TMO;
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if (inst_q == EBREAK_INST) begin
                    state_d = ST_HALT;
                end else if (opcode_legal(inst_q[6:0])) begin
                    state_d = ST_EXEC;
                end else begin
                    cause_d = CAUSE_ILLEGAL;
                    state_d = ST_TRAP;
                end
            end
            ST_EXEC:   if (!ex_busy) state_d = ST_WB;
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_IDLE;
        endcase
        if ((state_d == ST_FETCH) && (state_q != ST_FETCH)) begin
            addr_d = pc_in;
        end
        ex_start_d = (state_d == ST_EXEC) && (state_q != ST_EXEC);
    end

    always_ff @(posedge clk) begin
        if (global_rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            inst_q     <= RESET_INST;
            cause_q    <= CAUSE_NONE;
            ex_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            inst_q     <= inst_d;
            cause_q    <= cause_d;
            ex_start_q <= ex_start_d;
        end
    end

    // Every output is a register or a pure decode of registered state.
    assign imem_req   = (state_q == ST_FETCH);
    assign imem_addr  = addr_q;
    assign inst       = inst_q;
    assign ex_start   = ex_start_q;
    assign pc_we      = (state_q == ST_WB);
    assign reg_we     = pc_we && writes_rd(inst_q[6:0], inst_q[11:7]);
    assign halt       = (state_q == ST_HALT);
    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = trap ? cause_q : CAUSE_NONE;

`ifdef CORE_SEQ_RETIRE_CNT_EN
    logic [63:0] retire_q, retire_d;

    assign retire_d = (state_q == ST_WB) ? retire_q + 64'd1 : retire_q;

    always_ff @(posedge clk) begin
        if (global_rst) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_core_seq.sv
// Scoreboard bench for core_seq (FETCH_TIMEOUT=4): stimulus queues expected
// retire/trap/halt events, a negedge monitor pops and compares them.
module tb_core_seq;

    localparam int K_RET  = 0;
    localparam int K_TRAP = 1;
    localparam int K_HALT = 2;

    typedef struct {
        int          kind;
        logic        rwe;
        logic [31:0] addr;
        logic [31:0] word;
        logic [1:0]  cause;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        int          ack_dly;
        int          busy;
        logic        rwe;
    } vec_t;

    logic        clk = 1'b0;
    logic        global_rst;
    logic [31:0] pc_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        ex_start;
    logic        ex_busy;
    logic        reg_we;
    logic        pc_we;
    logic        halt;
    logic        trap;
    logic [1:0]  trap_cause;
`ifdef CORE_SEQ_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic mon_en    = 1'b0;
    logic trap_prev = 1'b0;
    logic halt_prev = 1'b0;

    core_seq #(.FETCH_TIMEOUT(4), .RESET_INST(32'h00000013)) dut (
        .clk        (clk),
        .global_rst (global_rst),
        .pc_in      (pc_in),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .ex_start   (ex_start),
        .ex_busy    (ex_busy),
        .reg_we     (reg_we),
        .pc_we      (pc_we),
        .halt       (halt),
        .trap       (trap),
        .trap_cause (trap_cause)
`ifdef CORE_SEQ_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int kind, input logic rwe, input logic [31:0] addr,
                            input logic [31:0] word, input logic [1:0] cause);
        exp_t e;
        e.kind = kind; e.rwe = rwe; e.addr = addr; e.word = word; e.cause = cause;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expected event per retire strobe / trap entry / halt entry.
    always @(negedge clk) begin
        exp_t e;
        int   kind;
        if (mon_en) begin
            chk("reg_we_outside_wb", {63'd0, reg_we & ~pc_we}, 64'd0);
            if (!trap) chk("trap_cause_outside_trap", {62'd0, trap_cause}, 64'd0);
            if (pc_we || (trap && !trap_prev) || (halt && !halt_prev)) begin
                kind = pc_we ? K_RET : (trap ? K_TRAP : K_HALT);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event actual=kind%0d required=none", kind);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", 64'(kind), 64'(e.kind));
                    if (e.kind == K_RET) begin
                        chk("wb_reg_we", {63'd0, reg_we}, {63'd0, e.rwe});
                        chk("wb_imem_addr", {32'd0, imem_addr}, {32'd0, e.addr});
                        chk("wb_inst", {32'd0, inst}, {32'd0, e.word});
                    end else if (e.kind == K_TRAP) begin
                        chk("trap_cause", {62'd0, trap_cause}, {62'd0, e.cause});
                    end
                end
            end
            trap_prev = trap;
            halt_prev = halt;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        global_rst = 1'b1;
        step();
        chk("rst_ctrl_outputs", {56'd0, imem_req, ex_start, reg_we, pc_we, halt, trap, trap_cause}, 64'd0);
        chk("rst_imem_addr", {32'd0, imem_addr}, 64'd0);
        chk("rst_inst", {32'd0, inst}, 64'h13);
`ifdef CORE_SEQ_RETIRE_CNT_EN
        chk("rst_retire_cnt", retire_cnt, 64'd0);
`endif
        global_rst = 1'b0;
        mon_en     = 1'b1;
    endtask

    task automatic wait_fetch(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!imem_req && n < 10);
        chk("fetch_reached", {63'd0, imem_req}, 64'd1);
    endtask

    task automatic run_instr(input vec_t v);
        int n, cyc, lat;
        pc_in = v.pc;
        push_exp(K_RET, v.rwe, v.pc, v.word, 2'b00);
        wait_fetch(n);
        chk("fetch_entry_cycles", 64'(n), 64'd1);
        chk("fetch_addr", {32'd0, imem_addr}, {32'd0, v.pc});
        lat = 1;
        repeat (v.ack_dly) begin
            step();
            lat++;
            chk("fetch_hold", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, v.pc});
        end
        imem_ack   = 1'b1;
        imem_rdata = v.word;
        step();
        lat++;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        chk("decode_inst", {31'd0, imem_req, inst}, {31'd0, 1'b0, v.word});
        ex_busy = (v.busy > 0);
        cyc = 0;
        do begin
            step();
            cyc++;
            if (!pc_we) begin
                chk("ex_start", {63'd0, ex_start}, {63'd0, cyc == 1});
                if (cyc == 1) begin
                    // Acks outside FETCH must not disturb the instruction register.
                    imem_ack   = 1'b1;
                    imem_rdata = 32'hDEADBEEF;
                end
                if (cyc == v.busy + 1) ex_busy = 1'b0;
            end
        end while (!pc_we && cyc < v.busy + 6);
        imem_ack   = 1'b0;
        imem_rdata = '0;
        ex_busy    = 1'b0;
        chk("wb_reached", {63'd0, pc_we}, 64'd1);
        chk("exec_cycles", 64'(cyc - 1), 64'(v.busy + 1));
        chk("wb_cycle_number", 64'(lat + cyc), 64'(4 + v.ack_dly + v.busy));
    endtask

    vec_t vecs[8];
    vec_t hv;

    initial begin
        int n, cnt, bad;
        global_rst = 1'b1;
        pc_in      = '0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        ex_busy    = 1'b0;

        vecs[0] = '{32'h80000000, 32'h00100093, 0, 0, 1'b1}; // addi x1
        vecs[1] = '{32'h80000004, 32'h00208063, 0, 3, 1'b0}; // beq, busy 3
        vecs[2] = '{32'h80000008, 32'h12345037, 1, 0, 1'b0}; // lui x0
        vecs[3] = '{32'h8000000C, 32'h008000EF, 0, 1, 1'b1}; // jal x1
        vecs[4] = '{32'h80000010, 32'h002081B3, 2, 0, 1'b1}; // add x3
        vecs[5] = '{32'h80000014, 32'h00112023, 0, 0, 1'b0}; // sw
        vecs[6] = '{32'h80000018, 32'h00000073, 0, 2, 1'b0}; // ecall
        vecs[7] = '{32'h8000001C, 32'h00100093, 3, 0, 1'b1}; // ack on last fetch cycle

        step();
        do_reset();
        foreach (vecs[i]) run_instr(vecs[i]);

        // Fetch timeout: four FETCH cycles without ack, then TRAP cause 10.
        pc_in = 32'h00000200;
        push_exp(K_TRAP, 1'b0, 32'h0, 32'h0, 2'b10);
        wait_fetch(n);
        cnt = 0;
        while (imem_req && cnt < 20) begin
            cnt++;
            step();
        end
        chk("timeout_fetch_cycles", 64'(cnt), 64'd4);
        chk("timeout_trap", {61'd0, trap, trap_cause}, {61'd0, 1'b1, 2'b10});
        do_reset();

        // Illegal opcode: TRAP cause 01, held for 100 cycles.
        pc_in = 32'h00000300;
        push_exp(K_TRAP, 1'b0, 32'h0, 32'h0, 2'b01);
        wait_fetch(n);
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFFFFFF;
        step();
        imem_ack   = 1'b0;
        step();
        chk("illegal_trap", {61'd0, trap, trap_cause}, {61'd0, 1'b1, 2'b01});
        bad = 0;
        repeat (100) begin
            step();
            if (!(trap && trap_cause == 2'b01 && !imem_req && !ex_start && !reg_we && !pc_we && !halt)) bad++;
        end
        chk("trap_hold_bad_cycles", 64'(bad), 64'd0);
        do_reset();

        // Three retired addi, then EBREAK halts.
        for (int i = 0; i < 3; i++) begin
            hv = '{32'h00001000 + 32'(4 * i), 32'h00100093, 0, 0, 1'b1};
            run_instr(hv);
        end
        pc_in = 32'h0000100C;
        push_exp(K_HALT, 1'b0, 32'h0, 32'h0, 2'b00);
        wait_fetch(n);
        imem_ack   = 1'b1;
        imem_rdata = 32'h00100073;
        step();
        imem_ack   = 1'b0;
        step();
        chk("halt_entry", {62'd0, halt, imem_req}, {62'd0, 1'b1, 1'b0});
`ifdef CORE_SEQ_RETIRE_CNT_EN
        chk("retire_cnt_at_halt", retire_cnt, 64'd3);
`endif
        bad = 0;
        repeat (20) begin
            step();
            if (imem_req || pc_we || reg_we || ex_start || !halt || trap) bad++;
        end
        chk("halt_hold_bad_cycles", 64'(bad), 64'd0);
`ifdef CORE_SEQ_RETIRE_CNT_EN
        chk("retire_cnt_after_halt", retire_cnt, 64'd3);
`endif
        do_reset();

        // Reset in the middle of EXEC.
        pc_in = 32'h00000400;
        wait_fetch(n);
        imem_ack   = 1'b1;
        imem_rdata = 32'h00100093;
        step();
        imem_ack   = 1'b0;
        ex_busy    = 1'b1;
        step();
        step();
        global_rst = 1'b1;
        step();
        global_rst = 1'b0;
        ex_busy    = 1'b0;
        chk("mid_exec_rst_outputs", {59'd0, imem_req, ex_start, reg_we, pc_we, halt}, 64'd0);
        step();
        chk("mid_exec_rst_req_rise", {63'd0, imem_req}, 64'd1);

        // Reset in the middle of FETCH.
        step();
        global_rst = 1'b1;
        step();
        global_rst = 1'b0;
        chk("mid_fetch_rst_outputs", {59'd0, imem_req, ex_start, reg_we, pc_we, trap}, 64'd0);
        step();
        chk("mid_fetch_rst_req_rise", {63'd0, imem_req}, 64'd1);

        do_reset();
        step();
        step();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
